lfsr_victim_select: RTL and testbench

- Cache replacement-way selector used in the I-cache and D-cache controllers.
- Picks the lowest-index invalid way when the set has one; otherwise picks a pseudo-random way from a 7-bit maximal-length LFSR.
- Binary-encodes the hit way and one-hot decodes the victim.
- Muxes the encoded hit or victim way onto a "way being updated" output for the replacement logic.

---
 rtl/lfsr_victim_select_if.sv | 34 +++
 rtl/lfsr_victim_select.sv | 81 ++++++++
 tb/tb_lfsr_victim_select.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/lfsr_victim_select_if.sv
// Bundle of the control, vector and result signals exchanged between a cache
// controller (master) and the replacement-way selector (slave).
//   FlushStage, LRUWriteEn, SetValid : controller strobes into the selector
//   HitWay, ValidWay                 : per-way tag-match and valid vectors
//   HitWayEnc, VictimWayEnc          : encoded hit / victim way indices
//   VictimWay                        : one-hot victim way
//   UpdateWayEnc                     : way index handed to the replacement logic
//   LfsrState                        : current LFSR state for debug visibility
interface lfsr_victim_select_if #(
  parameter int unsigned NUMWAYS = 4
);
  localparam int unsigned LOGNUMWAYS = $clog2(NUMWAYS);

  logic                  FlushStage;
  logic                  LRUWriteEn;
  logic                  SetValid;
  logic [NUMWAYS-1:0]    HitWay;
  logic [NUMWAYS-1:0]    ValidWay;
  logic [LOGNUMWAYS-1:0] HitWayEnc;
  logic [LOGNUMWAYS-1:0] VictimWayEnc;
  logic [NUMWAYS-1:0]    VictimWay;
  logic [LOGNUMWAYS-1:0] UpdateWayEnc;
  logic [6:0]            LfsrState;

  modport master (
    output FlushStage, LRUWriteEn, SetValid, HitWay, ValidWay,
    input  HitWayEnc, VictimWayEnc, VictimWay, UpdateWayEnc, LfsrState
  );

  modport slave (
    input  FlushStage, LRUWriteEn, SetValid, HitWay, ValidWay,
    output HitWayEnc, VictimWayEnc, VictimWay, UpdateWayEnc, LfsrState
  );
endinterface

// File: rtl/lfsr_victim_select.sv
// Cache replacement-way selector. Picks the lowest invalid way of the set, or a
// pseudo-random way from a 7-bit maximal-length LFSR when every way is valid.
// Also encodes the hit way and muxes hit/victim onto UpdateWayEnc.
//   clk   : rising-edge clock
//   reset : synchronous, active-low; reseeds the LFSR to 7'h01
//   bus   : slave side of lfsr_victim_select_if (see interface header)
module lfsr_victim_select #(
  parameter int unsigned NUMWAYS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  lfsr_victim_select_if.slave   bus
);
  localparam int unsigned LOGNUMWAYS = $clog2(NUMWAYS);
  localparam int unsigned LFSRW      = 7;
  localparam logic [LFSRW-1:0] LFSRSEED = 7'h01;

  logic [LFSRW-1:0]      lfsrQ;
  logic [LFSRW-1:0]      lfsrD;
  logic                  advanceEn;
  logic                  allValid;
  logic [LOGNUMWAYS-1:0] randIdx;
  logic [LOGNUMWAYS-1:0] firstZeroWay;
  logic                  zeroFound;
  logic [LOGNUMWAYS-1:0] hitEnc;
  logic [LOGNUMWAYS-1:0] victimEnc;

  // LFSR state register; reset wins over any advance in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsrQ <= LFSRSEED;
    end else begin
      lfsrQ <= lfsrD;
    end
  end

  // LFSR next state: right shift with x^7+x^6+1 style feedback into bit 6.
  always_comb begin
    advanceEn = bus.LRUWriteEn & ~bus.FlushStage;
    lfsrD     = lfsrQ;
    if (advanceEn) begin
      lfsrD = {lfsrQ[0] ^ lfsrQ[1], lfsrQ[LFSRW-1:1]};
    end
  end

  // Lowest-index invalid way; bit 0 has highest priority.
  always_comb begin
    firstZeroWay = '0;
    zeroFound    = 1'b0;
    for (int i = 0; i < int'(NUMWAYS); i++) begin
      if (!bus.ValidWay[i] && !zeroFound) begin
        firstZeroWay = LOGNUMWAYS'(i);
        zeroFound    = 1'b1;
      end
    end
  end

  // OR of set-bit indices: exact for one-hot, 0 for none, X-free for multi-hot.
  always_comb begin
    hitEnc = '0;
    for (int i = 0; i < int'(NUMWAYS); i++) begin
      if (bus.HitWay[i]) begin
        hitEnc = hitEnc | LOGNUMWAYS'(i);
      end
    end
  end

  // Victim choice and output muxing; no latency through this path.
  always_comb begin
    allValid  = &bus.ValidWay;
    randIdx   = lfsrQ[LOGNUMWAYS-1:0];
    victimEnc = allValid ? randIdx : firstZeroWay;
  end

  assign bus.HitWayEnc    = hitEnc;
  assign bus.VictimWayEnc = victimEnc;
  assign bus.VictimWay    = NUMWAYS'(1) << victimEnc;
  assign bus.UpdateWayEnc = bus.SetValid ? victimEnc : hitEnc;
  assign bus.LfsrState    = lfsrQ;

endmodule

// File: tb/tb_lfsr_victim_select.sv
// Directed bench for lfsr_victim_select with NUMWAYS=4.
module tb_lfsr_victim_select;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  lfsr_victim_select_if #(.NUMWAYS(4)) bus ();

  lfsr_victim_select #(.NUMWAYS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and let outputs settle away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] expState  [7];
    logic [1:0] expVictim [7];
    logic       seen [128];
    int         seenCount;
    logic [6:0] s;

    errors = 0;
    checks = 0;
    expState  = '{7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h41};
    expVictim = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd1};

    reset          = 1'b0;
    bus.FlushStage = 1'b0;
    bus.LRUWriteEn = 1'b0;
    bus.SetValid   = 1'b0;
    bus.HitWay     = 4'b0000;
    bus.ValidWay   = 4'hF;
    #2;
    step();
    chk("reset_lfsr", 32'(bus.LfsrState), 32'h01);
    chk("reset_victimEnc", 32'(bus.VictimWayEnc), 32'd1);
    chk("reset_victimWay", 32'(bus.VictimWay), 32'b0010);

    // Seven advances from the seed with a full set.
    reset = 1'b1;
    bus.LRUWriteEn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("seq_lfsr[%0d]", i), 32'(bus.LfsrState), 32'(expState[i]));
      chk($sformatf("seq_victim[%0d]", i), 32'(bus.VictimWayEnc), 32'(expVictim[i]));
    end
    bus.LRUWriteEn = 1'b0;

    // Invalid ways take priority over the random index, with no latency.
    bus.ValidWay = 4'b1011;
    #1;
    chk("v1011_enc", 32'(bus.VictimWayEnc), 32'd2);
    chk("v1011_way", 32'(bus.VictimWay), 32'b0100);
    chk("v1011_lfsr_hold", 32'(bus.LfsrState), 32'h41);
    bus.ValidWay = 4'b0000;
    #1;
    chk("v0000_enc", 32'(bus.VictimWayEnc), 32'd0);
    chk("v0000_way", 32'(bus.VictimWay), 32'b0001);
    bus.ValidWay = 4'b0111;
    #1;
    chk("v0111_enc", 32'(bus.VictimWayEnc), 32'd3);
    step();
    chk("idle_hold", 32'(bus.LfsrState), 32'h41);

    // Flush blocks advance.
    bus.LRUWriteEn = 1'b1;
    bus.FlushStage = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("flush_hold[%0d]", i), 32'(bus.LfsrState), 32'h41);
    end
    bus.FlushStage = 1'b0;

    // Reset dominates a concurrent advance.
    reset = 1'b0;
    step();
    chk("reset_dominates", 32'(bus.LfsrState), 32'h01);
    reset = 1'b1;
    bus.LRUWriteEn = 1'b0;

    // Hit encoding and the update-way mux.
    bus.HitWay   = 4'b1000;
    bus.SetValid = 1'b0;
    #1;
    chk("hit_enc", 32'(bus.HitWayEnc), 32'd3);
    chk("update_hit", 32'(bus.UpdateWayEnc), 32'd3);
    bus.SetValid = 1'b1;
    bus.ValidWay = 4'b0111;
    #1;
    chk("update_victim_inv", 32'(bus.UpdateWayEnc), 32'd3);
    bus.ValidWay = 4'hF;
    #1;
    chk("update_victim_rand", 32'(bus.UpdateWayEnc), 32'd1);
    bus.SetValid = 1'b0;
    bus.HitWay   = 4'b0000;
    #1;
    chk("hit_none", 32'(bus.HitWayEnc), 32'd0);
    bus.HitWay = 4'b0100;
    #1;
    chk("hit_way2", 32'(bus.HitWayEnc), 32'd2);
    bus.HitWay = 4'b0110;
    #1;
    chk("hit_multi", 32'(bus.HitWayEnc), 32'd3);
    bus.HitWay = 4'b0000;

    // Full period from the seed: 127 distinct nonzero states, back to 0x01.
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    seenCount = 1;
    bus.LRUWriteEn = 1'b1;
    for (int i = 0; i < 127; i++) begin
      step();
      s = bus.LfsrState;
      chk($sformatf("period_nonzero[%0d]", i), 32'(s == 7'h00), 32'd0);
      if (i < 126) begin
        chk($sformatf("period_unique[%0d]", i), 32'(seen[s]), 32'd0);
        if (!seen[s]) seenCount++;
        seen[s] = 1'b1;
      end
    end
    chk("period_return", 32'(bus.LfsrState), 32'h01);
    chk("period_count", 32'(seenCount), 32'd127);
    bus.LRUWriteEn = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
